// File: rtl/audio_pkg.sv
// Shared definitions for the ADSR envelope / audio output stage.
package audio_pkg;

    localparam int unsigned ENV_W    = 16;
    localparam int unsigned SAMPLE_W = 32;

    localparam logic [ENV_W-1:0] ENV_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_DECAY,
        ST_SUSTAIN,
        ST_RELEASE
    } adsr_state_e;

endpackage

// File: rtl/tick_div.sv
// Free-running divider: one-cycle pulse every DIV clocks, starting DIV clocks after reset.
module tick_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adsr_out_stage.sv
// ADSR envelope generator applied to a tone sample, feeding the Audio_Controller
// through a two-stage multiply / scale pipeline.
module adsr_out_stage
    import audio_pkg::*;
#(
    parameter int unsigned      UPDATE_DIV  = 50000,
    parameter int unsigned      SAMPLE_DIV  = 1042,
    parameter logic [ENV_W-1:0] ATTACK_INC  = 16'd64,
    parameter logic [ENV_W-1:0] DECAY_DEC   = 16'd16,
    parameter logic [ENV_W-1:0] SUSTAIN_LVL = 16'hC000,
    parameter logic [ENV_W-1:0] RELEASE_DEC = 16'd32
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic                gate,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                audio_out_allowed,
    output logic                write_audio_out,
    output logic [SAMPLE_W-1:0] left_channel_audio_out,
    output logic [SAMPLE_W-1:0] right_channel_audio_out,
    output logic [ENV_W-1:0]    env_level,
    output logic                active,
    output logic                underrun
);

    logic upd_tick;
    logic smp_strobe;

    tick_div #(.DIV(UPDATE_DIV)) u_upd_div (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .tick  (upd_tick)
    );

    tick_div #(.DIV(SAMPLE_DIV)) u_smp_div (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .tick  (smp_strobe)
    );

    logic        gate_q;
    logic        gate_rise;
    logic        gate_fall;
    adsr_state_e state_q;
    logic [ENV_W-1:0] env_q;
    logic        active_q;

    logic [ENV_W:0] atk_sum;
    logic [ENV_W:0] dec_diff;
    logic [ENV_W:0] rel_diff;
    logic           atk_sat;
    logic           dec_floor;
    logic           rel_floor;

    // Extra top bit catches overflow / borrow so saturation needs no wider compare.
    always_comb begin
        gate_rise = gate & ~gate_q;
        gate_fall = ~gate & gate_q;
        atk_sum   = {1'b0, env_q} + {1'b0, ATTACK_INC};
        dec_diff  = {1'b0, env_q} - {1'b0, DECAY_DEC};
        rel_diff  = {1'b0, env_q} - {1'b0, RELEASE_DEC};
        atk_sat   = atk_sum[ENV_W] | (atk_sum[ENV_W-1:0] == ENV_MAX);
        dec_floor = dec_diff[ENV_W] | (dec_diff[ENV_W-1:0] <= SUSTAIN_LVL);
        rel_floor = rel_diff[ENV_W] | (rel_diff[ENV_W-1:0] == '0);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            gate_q   <= 1'b0;
            state_q  <= ST_IDLE;
            env_q    <= '0;
            active_q <= 1'b0;
        end else begin
            gate_q <= gate;
            case (state_q)
                ST_IDLE: begin
                    env_q <= '0;
                    if (gate_rise) begin
                        state_q  <= ST_ATTACK;
                        active_q <= 1'b1;
                    end
                end
                ST_ATTACK: begin
                    if (gate_fall) begin
                        state_q <= ST_RELEASE;
                    end else if (upd_tick) begin
                        if (atk_sat) begin
                            env_q   <= ENV_MAX;
                            state_q <= ST_DECAY;
                        end else begin
                            env_q <= atk_sum[ENV_W-1:0];
                        end
                    end
                end
                ST_DECAY: begin
                    if (gate_fall) begin
                        state_q <= ST_RELEASE;
                    end else if (upd_tick) begin
                        if (dec_floor) begin
                            env_q   <= SUSTAIN_LVL;
                            state_q <= ST_SUSTAIN;
                        end else begin
                            env_q <= dec_diff[ENV_W-1:0];
                        end
                    end
                end
                ST_SUSTAIN: begin
                    env_q <= SUSTAIN_LVL;
                    if (gate_fall) begin
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (gate_rise) begin
                        state_q <= ST_ATTACK;
                    end else if (upd_tick) begin
                        if (rel_floor) begin
                            env_q    <= '0;
                            state_q  <= ST_IDLE;
                            active_q <= 1'b0;
                        end else begin
                            env_q <= rel_diff[ENV_W-1:0];
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    env_q    <= '0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    logic signed [48:0]  sample_ext;
    logic signed [48:0]  env_ext;
    logic signed [48:0]  prod_q;
    logic signed [48:0]  prod_d;
    logic                valid1_q;
    logic                valid1_d;
    logic [SAMPLE_W-1:0] out_q;
    logic [SAMPLE_W-1:0] out_d;
    logic                wr_q;
    logic                wr_d;
    logic                underrun_q;
    logic                underrun_d;
    logic                prod_unused;

    // Envelope gain is unsigned, so it enters the signed multiply zero-extended.
    always_comb begin
        sample_ext = {{17{sample_in[SAMPLE_W-1]}}, sample_in};
        env_ext    = {33'b0, env_q};
        prod_d     = prod_q;
        valid1_d   = 1'b0;
        out_d      = out_q;
        wr_d       = 1'b0;
        underrun_d = underrun_q;
        if (smp_strobe) begin
            if (audio_out_allowed) begin
                prod_d   = sample_ext * env_ext;
                valid1_d = 1'b1;
            end else begin
                underrun_d = 1'b1;
            end
        end
        if (valid1_q) begin
            out_d = prod_q[47:16];
            wr_d  = 1'b1;
        end
    end

    assign prod_unused = ^{prod_q[48], prod_q[15:0]};

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            prod_q     <= '0;
            valid1_q   <= 1'b0;
            out_q      <= '0;
            wr_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            prod_q     <= prod_d;
            valid1_q   <= valid1_d;
            out_q      <= out_d;
            wr_q       <= wr_d;
            underrun_q <= underrun_d;
        end
    end

    assign write_audio_out         = wr_q;
    assign left_channel_audio_out  = out_q;
    assign right_channel_audio_out = out_q;
    assign env_level               = env_q;
    assign active                  = active_q;
    assign underrun                = underrun_q;

endmodule

// File: tb/tb_adsr_out_stage.sv
// Self-checking bench for adsr_out_stage: envelope vector table plus scoreboarded audio writes.
module tb_adsr_out_stage;

    logic        clk;
    logic        rst_n;
    logic        gate;
    logic [31:0] sample_in;
    logic        allowed;
    logic        wr;
    logic [31:0] left_out;
    logic [31:0] right_out;
    logic [15:0] env_level;
    logic        active;
    logic        underrun;

    adsr_out_stage #(
        .UPDATE_DIV  (4),
        .SAMPLE_DIV  (8),
        .ATTACK_INC  (16'h4000),
        .DECAY_DEC   (16'h1000),
        .SUSTAIN_LVL (16'hC000),
        .RELEASE_DEC (16'h4000)
    ) dut (
        .CLOCK_50                (clk),
        .reset_n                 (rst_n),
        .gate                    (gate),
        .sample_in               (sample_in),
        .audio_out_allowed       (allowed),
        .write_audio_out         (wr),
        .left_channel_audio_out  (left_out),
        .right_channel_audio_out (right_out),
        .env_level               (env_level),
        .active                  (active),
        .underrun                (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ec;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ec <= 0;
        else        ec <= ec + 1;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        int data;
        int due;
    } sb_t;
    sb_t sbq[$];

    task automatic push_exp(input int data, input int due);
        sb_t e;
        e.data = data;
        e.due  = due;
        sbq.push_back(e);
    endtask

    // Scoreboard: every write must match the oldest expectation and arrive on its due edge.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wr) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_write", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        check("left_data", $signed(left_out), e.data);
                        check("right_data", $signed(right_out), e.data);
                        check("write_edge", ec, e.due);
                    end
                end else if (sbq.size() != 0 && ec > sbq[0].due) begin
                    e = sbq.pop_front();
                    check("missing_write", 0, 1);
                end
            end
        end
    end

    task automatic go_to(input int n);
        while (ec < n) @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_env"}, int'(env_level), 0);
        check({tag, "_active"}, int'(active), 0);
        check({tag, "_wr"}, int'(wr), 0);
        check({tag, "_left"}, $signed(left_out), 0);
        check({tag, "_right"}, $signed(right_out), 0);
        check({tag, "_underrun"}, int'(underrun), 0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        reset_checks(tag);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic gate;
        int   cycles;
        int   exp_env;
        logic exp_active;
    } env_vec_t;

    env_vec_t vecs[22];

    initial begin
        vecs[0]  = '{1'b1, 4, 'h4000, 1'b1};
        vecs[1]  = '{1'b1, 4, 'h8000, 1'b1};
        vecs[2]  = '{1'b1, 4, 'hC000, 1'b1};
        vecs[3]  = '{1'b1, 4, 'hFFFF, 1'b1};
        vecs[4]  = '{1'b1, 4, 'hEFFF, 1'b1};
        vecs[5]  = '{1'b1, 4, 'hDFFF, 1'b1};
        vecs[6]  = '{1'b1, 4, 'hCFFF, 1'b1};
        vecs[7]  = '{1'b1, 4, 'hC000, 1'b1};
        vecs[8]  = '{1'b1, 4, 'hC000, 1'b1};
        vecs[9]  = '{1'b0, 1, 'hC000, 1'b1};
        vecs[10] = '{1'b0, 3, 'h8000, 1'b1};
        vecs[11] = '{1'b0, 4, 'h4000, 1'b1};
        vecs[12] = '{1'b0, 4, 'h0000, 1'b0};
        vecs[13] = '{1'b0, 4, 'h0000, 1'b0};
        vecs[14] = '{1'b1, 1, 'h0000, 1'b1};
        vecs[15] = '{1'b1, 3, 'h4000, 1'b1};
        vecs[16] = '{1'b1, 4, 'h8000, 1'b1};
        vecs[17] = '{1'b1, 3, 'h8000, 1'b1};
        vecs[18] = '{1'b0, 1, 'h8000, 1'b1};
        vecs[19] = '{1'b1, 1, 'h8000, 1'b1};
        vecs[20] = '{1'b1, 3, 'hC000, 1'b1};
        vecs[21] = '{1'b1, 2, 'hC000, 1'b1};

        rst_n     = 1'b0;
        gate      = 1'b0;
        sample_in = '0;
        allowed   = 1'b0;
        @(negedge clk);
        #1;
        reset_checks("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Envelope walk with output writes blocked.
        for (int i = 0; i < 22; i++) begin
            gate = vecs[i].gate;
            repeat (vecs[i].cycles) @(negedge clk);
            check($sformatf("env_row%0d", i), int'(env_level), vecs[i].exp_env);
            check($sformatf("active_row%0d", i), int'(active), int'(vecs[i].exp_active));
        end
        check("underrun_blocked", int'(underrun), 1);

        do_reset("rst_mid_attack");

        // Audio path: attack from edge 5 puts 8000 at strobe 16 and FFFF at strobe 24.
        gate      = 1'b0;
        allowed   = 1'b1;
        sample_in = '0;
        go_to(4);
        gate = 1'b1;
        go_to(7);
        push_exp(0, 9);
        go_to(15);
        check("env_at_s16", int'(env_level), 'h8000);
        sample_in = -32'sd10000000;
        push_exp(-5000000, 17);
        go_to(23);
        check("env_at_s24", int'(env_level), 'hFFFF);
        sample_in = 32'sd10000000;
        push_exp(9999847, 25);
        go_to(26);
        check("wr_one_cycle", int'(wr), 0);
        check("hold_left", $signed(left_out), 9999847);
        go_to(31);
        allowed   = 1'b0;
        sample_in = 32'sd12345;
        go_to(32);
        check("underrun_set", int'(underrun), 1);
        go_to(33);
        allowed = 1'b1;
        go_to(34);
        check("blocked_hold_left", $signed(left_out), 9999847);
        check("blocked_hold_right", $signed(right_out), 9999847);
        go_to(39);
        sample_in = 32'sd20000;
        push_exp(15000, 41);
        go_to(42);
        check("underrun_sticky", int'(underrun), 1);
        go_to(48);
        do_reset("rst_mid_pipe");
        sample_in = '0;
        go_to(7);
        check("sb_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
